seq_multiplier: RTL
===================

# seq_multiplier

Sequential signed shift-add multiplier: the datapath stage directly downstream of the board control FSM. It captures two signed operands on a one-cycle `load` pulse and computes the product over a fixed number of cycles. It then raises a one-cycle `done` pulse that the control FSM uses as its completion signal. The product is held, along with a sign flag and magnitude for the display stage, until the next load.

## Interface
- `WIDTH`, 8, operand width in bits; product is 2·WIDTH bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high; highest priority.
- `clr`  in  1  synchronous clear; same effect as `rst`; beats `load` in the same cycle.
- `load`  in  1  one-cycle start strobe; samples `a_in` and `b_in`.
- `a_in`  in  WIDTH  multiplicand, two's complement.
- `b_in`  in  WIDTH  multiplier, two's complement.
- `product`  out  2·WIDTH  signed result, two's complement; held until the next accepted load.
- `product_neg`  out  1  1 when `product` < 0. A zero product always reports 0.
- `product_mag`  out  2·WIDTH  unsigned magnitude of `product`, for display.
- `busy`  out  1  high from the cycle after an accepted load until `done`.
- `done`  out  1  single-cycle pulse when the result is valid.

## Operation
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE, on `load`:
  - latch |a| and |b| as unsigned WIDTH-bit values; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - latch neg = sign(a) XOR sign(b).
  - clear the accumulator and iteration counter; go to CALC.
- CALC runs exactly WIDTH cycles. Each cycle:
  - if the multiplier-register LSB is 1, add the multiplicand register to the 2·WIDTH-bit accumulator;
  - then shift the multiplicand left 1 and the multiplier right 1;
  - increment the counter.
  - On the WIDTH-th iteration, go to SIGN.
- SIGN, one cycle:
  - `product` = neg ? −acc : acc;
  - `product_mag` = acc;
  - `product_neg` = neg AND (acc ≠ 0);
  - go to DONE with `done` registered high.
- DONE: `done` drops after one cycle; outputs hold. `load` restarts as from IDLE. The state stays in DONE otherwise.
- A `load` arriving in CALC or SIGN is ignored; no queuing.
- Latency is fixed and does not depend on data. There is no early termination.
- Width rules:
  - the accumulator is 2·WIDTH bits unsigned and cannot overflow, since max magnitude is 2^(2·WIDTH−2);
  - negation is two's complement in 2·WIDTH bits.

## Timing
- Reset/clear values:
  - state IDLE;
  - `product`, `product_mag` = 0;
  - `product_neg`, `busy`, `done` = 0;
  - internal registers = 0.
- `rst`/`clr` mid-operation aborts in the next cycle. Previous results are lost and no `done` is issued.
- With `load` sampled at edge E0:
  - `busy` = 1 after E0;
  - CALC occupies edges E1..E(WIDTH);
  - SIGN resolves at E(WIDTH+1), where `done` = 1 and `busy` = 0 and outputs update;
  - `done` = 0 after E(WIDTH+2).
- Load-to-done latency is WIDTH+1 cycles: 9 for WIDTH=8.
- `product` outputs change only at the SIGN edge and on reset/clear. They are stable for the entire DONE/IDLE interval.
- Back-to-back: a `load` in the DONE cycle where `done` = 1 is accepted. The next `done` follows WIDTH+1 cycles later.

## Structure
- Shared package `mult_pkg`:
  - state enum (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3);
  - default `WIDTH` constant;
  - counter width $clog2(WIDTH+1).
- Single module; FSM and datapath together. No sub-module needed; absolute value and negation are inline expressions.

## Test plan
- Basic: `rst`, then load a=7, b=6. Expect `done` exactly 9 cycles after load, `product`=42 (0x002A), `product_neg`=0, `product_mag`=42.
- Signs:
  - a=−3 (0xFD), b=5: `product`=0xFFF1 (−15), `product_neg`=1, `product_mag`=15.
  - a=−4, b=−9: `product`=36, `product_neg`=0.
- Extremes:
  - a=b=−128: `product`=0x4000 (16384).
  - a=−128, b=127: `product`=0xC080 (−16256).
- Zero: a=0, b=−5. Expect `product`=0, `product_neg`=0, `product_mag`=0.
- Ignored load: load 3×3, then pulse `load` with 10×10 at cycle 4. Expect `product`=9, a single `done`, `busy` never re-asserted early.
- Abort and restart:
  - assert `rst` at cycle 5 of CALC: next cycle all outputs 0, no `done`;
  - then load 2×2 in the `done` cycle of a prior op: `product`=4 after 9 cycles;
  - `clr` and `load` in the same cycle: stays IDLE.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding and sizing helpers for the sequential multiplier
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: signed shift-add multiplier, WIDTH iterations on operand magnitudes then sign fix-up
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               product_neg,
  output logic [2*WIDTH-1:0] product_mag,
  output logic               busy,
  output logic               done
);
  localparam int CW = cnt_w(WIDTH);
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] mag_q, mag_d;
  logic               pneg_q, pneg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               accept;
  assign abs_a  = a_in[WIDTH-1] ? -a_in : a_in;
  assign abs_b  = b_in[WIDTH-1] ? -b_in : b_in;
  assign accept = load && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    mag_d     = mag_q;
    pneg_d    = pneg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      CALC: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CW'(WIDTH - 1)) ? SIGN : CALC;
      end
      SIGN: begin
        product_d = neg_q ? -acc_q : acc_q;
        mag_d     = acc_q;
        pneg_d    = neg_q && (acc_q != '0);
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      default: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      mag_q     <= '0;
      pneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      mag_q     <= mag_d;
      pneg_q    <= pneg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign product     = product_q;
  assign product_mag = mag_q;
  assign product_neg = pneg_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule
